tmr_voter_seq: RTL and testbench

Registered, parametrised triple-modular-redundancy voter for WIDTH-bit buses. It performs a bitwise majority vote and tracks per-lane disagreement with saturating error counters. A lane is retired after FAULT_TH consecutive mismatches, and the block degrades from triplex to duplex to failed operation. It sits between three redundant datapath copies and the single downstream consumer.

---
 rtl/tmr_pkg.sv | 24 ++
 rtl/tmr_lane_monitor.sv | 63 ++++++
 rtl/tmr_voter_seq.sv | 150 +++++++++++++++
 tb/tb_tmr_voter_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared mode encoding and helpers for the TMR voter.
package tmr_pkg;

  typedef enum logic [1:0] {
    TRIPLEX = 2'd0,
    DUPLEX  = 2'd1,
    FAILED  = 2'd2
  } mode_e;

  // Number of set bits in a 3-bit vector (used for the retired-lane count).
  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Operating mode implied by a set of retired lanes.
  function automatic mode_e mode_of_faults(input logic [2:0] flt);
    logic [1:0] n;
    n = popcnt3(flt);
    if (n == 2'd0)      return TRIPLEX;
    else if (n == 2'd1) return DUPLEX;
    else                return FAILED;
  endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane disagreement tracker: consecutive-mismatch run length, sticky
// retirement flag and saturating total mismatch count.
module tmr_lane_monitor
  import tmr_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int FAULT_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en_i,
  input  logic             mismatch_i,
  input  logic             clr_i,
  output logic             fault_o,
  output logic             fault_nxt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0]       TH      = 8'(FAULT_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       consec_q, consec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fault_q, fault_d;

  // Next-state: clear wins; otherwise only counted samples move the counters.
  always_comb begin
    consec_d = consec_q;
    err_d    = err_q;
    fault_d  = fault_q;
    if (clr_i) begin
      consec_d = '0;
      err_d    = '0;
      fault_d  = 1'b0;
    end else if (cnt_en_i) begin
      if (mismatch_i) begin
        consec_d = (consec_q >= TH) ? TH : consec_q + 8'd1;
        err_d    = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;
        if (consec_d == TH) fault_d = 1'b1;
      end else begin
        consec_d = '0;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec_q <= '0;
      err_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      consec_q <= consec_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
    end
  end

  assign fault_o     = fault_q;
  assign fault_nxt_o = fault_d;
  assign err_cnt_o   = err_q;

endmodule

// File: rtl/tmr_voter_seq.sv
// Registered TMR voter: bitwise majority in triplex, pairwise compare in
// duplex, frozen output once two lanes are retired.
module tmr_voter_seq
  import tmr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int FAULT_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_fault,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic [2:0]       mismatch,
  output logic [2:0]       fault,
  output logic [1:0]       mode,
  output logic             dup_err,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  logic [2:0][WIDTH-1:0] lanes;
  logic [WIDTH-1:0]      voted, sx, sy;
  logic [2:0]            mm_vote, fault_nxt;
  logic [2:0][CNT_W-1:0] err_cnt;
  logic                  cnt_en;

  logic [WIDTH-1:0] f_q, f_d;
  logic [2:0]       mm_q, mm_d;
  logic             ov_q, ov_d;
  logic             dup_q, dup_d;
  mode_e            mode_q, mode_d;

  assign lanes = {c, b, a};
  assign voted = (a & b) | (a & c) | (b & c);

  // Per-lane disagreement with the triplex vote.
  always_comb begin
    mm_vote = '0;
    for (int k = 0; k < 3; k++) mm_vote[k] = (lanes[k] != voted);
  end

  // Surviving pair while in duplex (exactly one lane is retired there).
  always_comb begin
    sx = a;
    sy = b;
    if (fault[0]) begin
      sx = b;
      sy = c;
    end else if (fault[1]) begin
      sx = a;
      sy = c;
    end
  end

  // Output/mode next-state; invalid cycles hold everything but out_valid.
  always_comb begin
    f_d    = f_q;
    mm_d   = mm_q;
    dup_d  = dup_q;
    ov_d   = 1'b0;
    mode_d = mode_q;
    cnt_en = 1'b0;
    if (clr_fault) begin
      mode_d = TRIPLEX;
      if (in_valid) begin
        f_d   = voted;
        mm_d  = mm_vote;
        dup_d = 1'b0;
        ov_d  = 1'b1;
      end
    end else if (in_valid) begin
      ov_d = 1'b1;
      case (mode_q)
        TRIPLEX: begin
          f_d    = voted;
          mm_d   = mm_vote;
          dup_d  = 1'b0;
          cnt_en = 1'b1;
          mode_d = mode_of_faults(fault_nxt);
        end
        DUPLEX: begin
          if (sx == sy) begin
            f_d   = sx;
            dup_d = 1'b0;
          end else begin
            dup_d = 1'b1;
          end
          for (int k = 0; k < 3; k++)
            mm_d[k] = !fault[k] && (lanes[k] != f_d);
        end
        default: begin
          mm_d  = '0;
          dup_d = 1'b0;
        end
      endcase
    end
  end

  // Output and mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      mm_q   <= '0;
      ov_q   <= 1'b0;
      dup_q  <= 1'b0;
      mode_q <= TRIPLEX;
    end else begin
      f_q    <= f_d;
      mm_q   <= mm_d;
      ov_q   <= ov_d;
      dup_q  <= dup_d;
      mode_q <= mode_d;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_mon
    tmr_lane_monitor #(
      .CNT_W   (CNT_W),
      .FAULT_TH(FAULT_TH)
    ) u_mon (
      .clk        (clk),
      .rst        (rst),
      .cnt_en_i   (cnt_en),
      .mismatch_i (mm_vote[k]),
      .clr_i      (clr_fault),
      .fault_o    (fault[k]),
      .fault_nxt_o(fault_nxt[k]),
      .err_cnt_o  (err_cnt[k])
    );
  end

  assign f         = f_q;
  assign mismatch  = mm_q;
  assign out_valid = ov_q;
  assign dup_err   = dup_q;
  assign mode      = mode_q;
  assign fail      = (mode_q == FAILED);
  assign err_cnt_a = err_cnt[0];
  assign err_cnt_b = err_cnt[1];
  assign err_cnt_c = err_cnt[2];

endmodule

// File: tb/tb_tmr_voter_seq.sv
// Directed bench for tmr_voter_seq: a behavioural model checked every cycle
// plus literal expectations at the interesting points.
module tb_tmr_voter_seq;

  localparam int W  = 8;
  localparam int TH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, clr_fault = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;

  logic         ov1, dup1, fail1, ov2, dup2, fail2;
  logic [W-1:0] f1, f2;
  logic [2:0]   mm1, flt1, mm2, flt2;
  logic [1:0]   mode1, mode2;
  logic [7:0]   ea1, eb1, ec1;
  logic [1:0]   ea2, eb2, ec2;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  tmr_voter_seq #(.WIDTH(W), .CNT_W(8), .FAULT_TH(TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_fault(clr_fault), .out_valid(ov1), .f(f1), .mismatch(mm1),
    .fault(flt1), .mode(mode1), .dup_err(dup1), .fail(fail1),
    .err_cnt_a(ea1), .err_cnt_b(eb1), .err_cnt_c(ec1));

  tmr_voter_seq #(.WIDTH(W), .CNT_W(2), .FAULT_TH(TH)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_fault(clr_fault), .out_valid(ov2), .f(f2), .mismatch(mm2),
    .fault(flt2), .mode(mode2), .dup_err(dup2), .fail(fail2),
    .err_cnt_a(ea2), .err_cnt_b(eb2), .err_cnt_c(ec2));

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_f = '0;
  logic [2:0]   m_mm = '0, m_fault = '0;
  int m_mode = 0, m_ov = 0, m_dup = 0;
  int m_consec[3] = '{0, 0, 0};
  int m_raw[3]    = '{0, 0, 0};

  function automatic logic [W-1:0] majority(input logic [W-1:0] x, y, z);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    logic [W-1:0] l[3];
    int s[2];
    int ns, nf;
    l[0] = a; l[1] = b; l[2] = c;
    if (rst) begin
      m_f = '0; m_mm = '0; m_fault = '0; m_mode = 0; m_ov = 0; m_dup = 0;
      for (int k = 0; k < 3; k++) begin m_consec[k] = 0; m_raw[k] = 0; end
      return;
    end
    m_ov = 0;
    if (clr_fault) begin
      m_fault = '0; m_mode = 0;
      for (int k = 0; k < 3; k++) begin m_consec[k] = 0; m_raw[k] = 0; end
      if (in_valid) begin
        m_f = majority(a, b, c); m_dup = 0; m_ov = 1;
        for (int k = 0; k < 3; k++) m_mm[k] = (l[k] != m_f);
      end
    end else if (in_valid) begin
      m_ov = 1;
      if (m_mode == 0) begin
        m_f = majority(a, b, c); m_dup = 0;
        for (int k = 0; k < 3; k++) begin
          m_mm[k] = (l[k] != m_f);
          if (m_mm[k]) begin
            m_raw[k]++;
            if (m_consec[k] < TH) m_consec[k]++;
            if (m_consec[k] == TH) m_fault[k] = 1'b1;
          end else m_consec[k] = 0;
        end
        nf = int'(m_fault[0]) + int'(m_fault[1]) + int'(m_fault[2]);
        m_mode = (nf == 0) ? 0 : (nf == 1) ? 1 : 2;
      end else if (m_mode == 1) begin
        ns = 0; s[0] = 0; s[1] = 0;
        for (int k = 0; k < 3; k++) if (!m_fault[k] && ns < 2) begin s[ns] = k; ns++; end
        if (l[s[0]] == l[s[1]]) begin m_f = l[s[0]]; m_dup = 0; end
        else m_dup = 1;
        for (int k = 0; k < 3; k++) m_mm[k] = !m_fault[k] && (l[k] != m_f);
      end else begin
        m_mm = '0; m_dup = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("f", 32'(f1), 32'(m_f));            chk("f2", 32'(f2), 32'(m_f));
    chk("out_valid", 32'(ov1), m_ov);      chk("out_valid2", 32'(ov2), m_ov);
    chk("mismatch", 32'(mm1), 32'(m_mm));  chk("mismatch2", 32'(mm2), 32'(m_mm));
    chk("fault", 32'(flt1), 32'(m_fault)); chk("fault2", 32'(flt2), 32'(m_fault));
    chk("mode", 32'(mode1), m_mode);       chk("mode2", 32'(mode2), m_mode);
    chk("dup_err", 32'(dup1), m_dup);      chk("dup_err2", 32'(dup2), m_dup);
    chk("fail", 32'(fail1), (m_mode == 2)); chk("fail2", 32'(fail2), (m_mode == 2));
    chk("err_a", 32'(ea1), sat(m_raw[0], 255)); chk("err_a2", 32'(ea2), sat(m_raw[0], 3));
    chk("err_b", 32'(eb1), sat(m_raw[1], 255)); chk("err_b2", 32'(eb2), sat(m_raw[1], 3));
    chk("err_c", 32'(ec1), sat(m_raw[2], 255)); chk("err_c2", 32'(ec2), sat(m_raw[2], 3));
  endtask

  initial forever begin
    @(negedge clk);
    if (started) cmp_all();
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [W-1:0] aa, bb, cc, input logic clr = 1'b0);
    in_valid = v; a = aa; b = bb; c = cc; clr_fault = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), W'($urandom));
  endtask

  initial begin
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_f", 32'(f1), 0); chk("rst_ov", 32'(ov1), 0); chk("rst_mode", 32'(mode1), 0);
    rst = 1'b0;
    idle(1);

    // agreement
    step(1, 8'h5A, 8'h5A, 8'h5A);
    chk("agree_f", 32'(f1), 32'h5A); chk("agree_ov", 32'(ov1), 1); chk("agree_mm", 32'(mm1), 0);
    // single-bit upset on b
    step(1, 8'h5A, 8'h5B, 8'h5A);
    chk("upset_f", 32'(f1), 32'h5A); chk("upset_mm", 32'(mm1), 3'b010);
    chk("upset_eb", 32'(eb1), 1); chk("upset_fault", 32'(flt1), 0);
    // interrupted run: 2 mismatches then a match at sample 3
    step(1, 8'h5A, 8'h5A, 8'h5A);
    step(1, 8'h5A, 8'h5B, 8'h5A);
    step(1, 8'h5A, 8'hFF, 8'h5A);
    step(1, 8'h5A, 8'h5A, 8'h5A);
    chk("interrupt_fault", 32'(flt1), 0); chk("interrupt_eb", 32'(eb1), 3);
    // four consecutive mismatches retire b, with idles in between
    step(1, 8'h5A, 8'h00, 8'h5A);
    step(1, 8'h5A, 8'h01, 8'h5A);
    idle(2);
    step(1, 8'h5A, 8'h02, 8'h5A);
    chk("pre_retire_fault", 32'(flt1), 0); chk("pre_retire_mode", 32'(mode1), 0);
    step(1, 8'h5A, 8'h03, 8'h5A);
    chk("retire_fault", 32'(flt1), 3'b010); chk("retire_mode", 32'(mode1), 1);
    chk("retire_f", 32'(f1), 32'h5A); chk("retire_eb", 32'(eb1), 7);
    idle(2);
    chk("idle_ov", 32'(ov1), 0); chk("idle_f", 32'(f1), 32'h5A);
    // duplex disagreement and agreement
    step(1, 8'h10, 8'h99, 8'h11);
    chk("dup_f", 32'(f1), 32'h5A); chk("dup_err", 32'(dup1), 1);
    chk("dup_mm", 32'(mm1), 3'b101); chk("dup_ov", 32'(ov1), 1);
    step(1, 8'h22, 8'h00, 8'h22);
    chk("dupok_f", 32'(f1), 32'h22); chk("dupok_err", 32'(dup1), 0);
    // plain clear
    step(0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("clr_mode", 32'(mode1), 0); chk("clr_fault", 32'(flt1), 0); chk("clr_eb", 32'(eb1), 0);
    chk("clr_f_hold", 32'(f1), 32'h22);
    // a and c retire on the same edge
    for (int i = 0; i < TH; i++) step(1, 8'h01, 8'h00, 8'h02);
    chk("failed_mode", 32'(mode1), 2); chk("failed_fail", 32'(fail1), 1);
    chk("failed_fault", 32'(flt1), 3'b101); chk("failed_f", 32'(f1), 0);
    step(1, 8'h77, 8'h77, 8'h77);
    chk("frozen_f", 32'(f1), 0); chk("frozen_ov", 32'(ov1), 1);
    // clear with a valid sample
    step(1, 8'h33, 8'h33, 8'h33, 1'b1);
    chk("clrv_f", 32'(f1), 32'h33); chk("clrv_mode", 32'(mode1), 0);
    chk("clrv_ea", 32'(ea1), 0); chk("clrv_ec", 32'(ec1), 0); chk("clrv_ov", 32'(ov1), 1);
    // saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) step(1, 8'h01, 8'h00, 8'h00);
    chk("sat_ea8", 32'(ea1), 4); chk("sat_ea2", 32'(ea2), 3);
    chk("sat_fault", 32'(flt1), 3'b001); chk("sat_mode", 32'(mode1), 1);
    // asynchronous reset mid-stream
    step(1, 8'h44, 8'h44, 8'h44);
    chk("pre_rst_f", 32'(f1), 32'h44); chk("pre_rst_ov", 32'(ov1), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_f", 32'(f1), 0); chk("async_ov", 32'(ov1), 0); chk("async_mode", 32'(mode1), 0);
    chk("async_fault", 32'(flt1), 0); chk("async_ea", 32'(ea1), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h66, 8'h66, 8'h67);
    chk("post_rst_f", 32'(f1), 32'h66); chk("post_rst_mm", 32'(mm1), 3'b100);
    chk("post_rst_ec", 32'(ec1), 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
